// File: rtl/conversao_pkg.sv
// ----------------------------------------------------------------------------
// conversao_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   NUM_BITS        : width of the binary operand
//   NUM_DIGITOS     : BCD digits presented on the output
//   NUM_DIGITOS_ACC : digits kept internally (one extra to detect overflow)
//   BCD_LIMITE      : largest value representable in NUM_DIGITOS digits
//   estado_t        : converter FSM states
// ----------------------------------------------------------------------------
package conversao_pkg;

    localparam int NUM_BITS        = 16;
    localparam int NUM_DIGITOS     = 4;
    localparam int NUM_DIGITOS_ACC = NUM_DIGITOS + 1;
    localparam int BCD_LIMITE      = 9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } estado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// ----------------------------------------------------------------------------
// ajuste_bcd
// Combinational single-digit corrector for the shift-and-add-3 algorithm.
// A digit of 5 or more gets 3 added so that the following left shift carries
// correctly into the next decimal digit. Inputs never exceed 9, so the
// +3 result always fits in 4 bits.
//   i_digito : BCD digit before correction
//   o_digito : corrected digit
// ----------------------------------------------------------------------------
module ajuste_bcd
    import conversao_pkg::*;
(
    input  logic [3:0] i_digito,
    output logic [3:0] o_digito
);

    assign o_digito = (i_digito >= 4'd5) ? (i_digito + 4'd3) : i_digito;

endmodule

// File: rtl/conversaobin_bcd_seq.sv
// ----------------------------------------------------------------------------
// conversaobin_bcd_seq
// Sequential 16-bit binary to packed-BCD converter, one bit per clock, using
// shift-and-add-3. A five-digit accumulator is kept internally so that values
// above 9999 are flagged through erro instead of silently truncated.
//   clock          : system clock, rising edge
//   reset_n        : asynchronous active-low reset
//   start          : conversion request, only honoured in IDLE
//   registradorin  : binary operand, captured on the accepting edge
//   registradorout : packed BCD result {thousands, hundreds, tens, units}
//   erro           : operand exceeded 9999 (valid together with the result)
//   busy           : conversion in progress (SHIFT or DONE)
//   pronto         : one-cycle pulse when registradorout/erro are updated
// ----------------------------------------------------------------------------
module conversaobin_bcd_seq
    import conversao_pkg::*;
#(
    parameter int NUM_BITS    = conversao_pkg::NUM_BITS,
    parameter int NUM_DIGITOS = conversao_pkg::NUM_DIGITOS
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [NUM_BITS-1:0]      registradorin,
    output logic [4*NUM_DIGITOS-1:0] registradorout,
    output logic                     erro,
    output logic                     busy,
    output logic                     pronto
);

    localparam int ACC_W = 4 * (NUM_DIGITOS + 1);
    localparam int OUT_W = 4 * NUM_DIGITOS;

    estado_t             r_estado;
    logic [NUM_BITS-1:0] r_deslocamento;
    logic [ACC_W-1:0]    r_acumulador;
    logic [4:0]          r_contador;

    logic [ACC_W-1:0]    w_corrigido;
    logic [ACC_W-1:0]    w_proximoAcc;

    // Every accumulator digit is corrected in parallel from its pre-shift value
    genvar g;
    generate
        for (g = 0; g < NUM_DIGITOS + 1; g++) begin : g_ajuste
            ajuste_bcd u_ajuste (
                .i_digito (r_acumulador[4*g +: 4]),
                .o_digito (w_corrigido[4*g +: 4])
            );
        end
    endgenerate

    // Accumulator after correction and one left shift of {acc, shift register};
    // the MSB of the binary operand enters the units digit
    assign w_proximoAcc = {w_corrigido[ACC_W-2:0], r_deslocamento[NUM_BITS-1]};

    // Converter FSM. The result registers are only written on the edge that
    // performs the last shift, so the outputs never expose partial values and
    // hold the previous result for the whole conversion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado       <= IDLE;
            r_deslocamento <= '0;
            r_acumulador   <= '0;
            r_contador     <= '0;
            registradorout <= '0;
            erro           <= 1'b0;
            busy           <= 1'b0;
            pronto         <= 1'b0;
        end else begin
            case (r_estado)
                IDLE: begin
                    pronto <= 1'b0;
                    if (start) begin
                        r_deslocamento <= registradorin;
                        r_acumulador   <= '0;
                        r_contador     <= '0;
                        busy           <= 1'b1;
                        r_estado       <= SHIFT;
                    end
                end

                SHIFT: begin
                    r_acumulador   <= w_proximoAcc;
                    r_deslocamento <= {r_deslocamento[NUM_BITS-2:0], 1'b0};
                    r_contador     <= r_contador + 5'd1;
                    // Counter still shows the shift count before this edge
                    if (r_contador == 5'(NUM_BITS - 1)) begin
                        registradorout <= w_proximoAcc[OUT_W-1:0];
                        erro           <= |w_proximoAcc[ACC_W-1:OUT_W];
                        pronto         <= 1'b1;
                        r_estado       <= DONE;
                    end
                end

                DONE: begin
                    pronto   <= 1'b0;
                    busy     <= 1'b0;
                    r_estado <= IDLE;
                end

                default: begin
                    pronto   <= 1'b0;
                    busy     <= 1'b0;
                    r_estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversaobin_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_conversaobin_bcd_seq
// Self-checking bench for conversaobin_bcd_seq. Expected results come from a
// decimal-division model and are queued when a conversion is requested, then
// popped and compared when pronto is seen.
// ----------------------------------------------------------------------------
module tb_conversaobin_bcd_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] registradorin = 16'h0000;
    logic [15:0] registradorout;
    logic        erro;
    logic        busy;
    logic        pronto;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entries: {erro, registradorout}
    logic [16:0] expQ[$];

    conversaobin_bcd_seq #(
        .NUM_BITS    (16),
        .NUM_DIGITOS (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .registradorin  (registradorin),
        .registradorout (registradorout),
        .erro           (erro),
        .busy           (busy),
        .pronto         (pronto)
    );

    always #5 clock = ~clock;

    // Reference model: decimal digits by division, overflow above 9999
    function automatic logic [16:0] modelo(input int valor);
        int resto;
        logic [15:0] bcd;
        resto = valor % 10000;
        bcd[15:12] = 4'((resto / 1000) % 10);
        bcd[11:8]  = 4'((resto / 100) % 10);
        bcd[7:4]   = 4'((resto / 10) % 10);
        bcd[3:0]   = 4'(resto % 10);
        return {(valor > 9999), bcd};
    endfunction

    // Drives a one-cycle start; returns on the falling edge after the accepting edge
    task automatic pulseStart(input logic [15:0] valor);
        @(negedge clock);
        registradorin = valor;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Waits at most 'limite' cycles for pronto; latencia = -1 on timeout
    task automatic waitPronto(input int limite, output int latencia);
        latencia = -1;
        for (int k = 1; k <= limite; k++) begin
            @(negedge clock);
            if (pronto === 1'b1) begin
                latencia = k;
                break;
            end
        end
    endtask

    function automatic logic [16:0] popExp();
        if (expQ.size() == 0) return 17'h1FFFF;
        return expQ.pop_front();
    endfunction

    task automatic test_reset();
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (registradorout !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_out got=%h want=0000", registradorout);
        end
        checks++;
        if ({erro, busy, pronto} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags got erro/busy/pronto=%b want=000", {erro, busy, pronto});
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_conversions();
        logic [15:0] tabela[5];
        logic [16:0] esperado;
        int lat;
        tabela = '{16'h0000, 16'h04D2, 16'h270F, 16'h2710, 16'hFFFF};
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(modelo(int'(tabela[i])));
            pulseStart(tabela[i]);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL conv_busy op=%h got=%b want=1", tabela[i], busy);
            end
            waitPronto(40, lat);
            checks++;
            if (lat < 0) begin
                failures++;
                $display("[TB] FAIL conv_timeout op=%h no pronto within 40 cycles", tabela[i]);
                void'(popExp());
                continue;
            end
            // lat counts from the cycle after the accepting edge
            if (lat + 1 !== 17 - 1 + 1 - 0 + 0 - 1 + 1) begin
                failures++;
                $display("[TB] FAIL conv_latency op=%h got=%0d want=16", tabela[i], lat);
            end
            esperado = popExp();
            checks++;
            if (registradorout !== esperado[15:0]) begin
                failures++;
                $display("[TB] FAIL conv_bcd op=%h got=%h want=%h", tabela[i], registradorout, esperado[15:0]);
            end
            checks++;
            if (erro !== esperado[16]) begin
                failures++;
                $display("[TB] FAIL conv_erro op=%h got=%b want=%b", tabela[i], erro, esperado[16]);
            end
            @(negedge clock);
            checks++;
            if ({busy, pronto} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL conv_idle op=%h got busy/pronto=%b want=00", tabela[i], {busy, pronto});
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [16:0] esperado;
        int lat;
        bit visto;
        expQ.push_back(modelo(7));
        pulseStart(16'h0007);
        repeat (3) @(negedge clock);
        registradorin = 16'h0063;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitPronto(30, lat);
        esperado = popExp();
        checks++;
        if (lat < 0 || registradorout !== esperado[15:0] || erro !== esperado[16]) begin
            failures++;
            $display("[TB] FAIL ignore_result lat=%0d got=%b/%h want=%b/%h", lat, erro, registradorout, esperado[16], esperado[15:0]);
        end
        visto = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (pronto === 1'b1) visto = 1'b1;
        end
        checks++;
        if (visto !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignore_extra_pronto got=1 want=0");
        end
        expQ.push_back(modelo(99));
        pulseStart(16'h0063);
        waitPronto(40, lat);
        esperado = popExp();
        checks++;
        if (lat < 0 || registradorout !== esperado[15:0] || erro !== esperado[16]) begin
            failures++;
            $display("[TB] FAIL ignore_later lat=%0d got=%b/%h want=%b/%h", lat, erro, registradorout, esperado[16], esperado[15:0]);
        end
    endtask

    task automatic test_reset_abort();
        logic [16:0] esperado;
        int lat;
        bit visto;
        expQ.push_back(modelo(1234));
        pulseStart(16'h04D2);
        waitPronto(40, lat);
        esperado = popExp();
        checks++;
        if (lat < 0 || registradorout !== esperado[15:0]) begin
            failures++;
            $display("[TB] FAIL abort_pre lat=%0d got=%h want=%h", lat, registradorout, esperado[15:0]);
        end
        @(negedge clock);
        pulseStart(16'h0050);
        repeat (7) @(negedge clock);
        // Mid-cycle, away from any clock edge: outputs must clear immediately
        reset_n = 1'b0;
        #1;
        checks++;
        if ({registradorout, erro, busy, pronto} !== 19'h0) begin
            failures++;
            $display("[TB] FAIL abort_async got out=%h erro/busy/pronto=%b want=0000/000", registradorout, {erro, busy, pronto});
        end
        visto = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (pronto === 1'b1) visto = 1'b1;
        end
        reset_n = 1'b1;
        repeat (25) begin
            @(negedge clock);
            if (pronto === 1'b1 || busy === 1'b1) visto = 1'b1;
        end
        checks++;
        if (visto !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_pronto got activity=1 want=0");
        end
        expQ.push_back(modelo(80));
        pulseStart(16'h0050);
        waitPronto(40, lat);
        esperado = popExp();
        checks++;
        if (lat < 0 || registradorout !== esperado[15:0] || erro !== esperado[16]) begin
            failures++;
            $display("[TB] FAIL abort_after lat=%0d got=%b/%h want=%b/%h", lat, erro, registradorout, esperado[16], esperado[15:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] esperado;
        int nPronto;
        int ultimo;
        int espaco;
        int lat;
        bit seguido;
        nPronto = 0;
        ultimo  = -1;
        espaco  = -1;
        seguido = 1'b0;
        @(negedge clock);
        registradorin = 16'h000A;
        start = 1'b1;
        // With start held, a new conversion is accepted every 18 edges
        for (int i = 0; i < 40; i++) begin
            if (i % 18 == 0) expQ.push_back(modelo(10));
            @(negedge clock);
            if (pronto === 1'b1) begin
                if (ultimo == i) seguido = 1'b1;
                if (ultimo >= 0) espaco = i + 1 - ultimo;
                ultimo = i + 1;
                nPronto++;
                esperado = popExp();
                checks++;
                if (registradorout !== esperado[15:0] || erro !== esperado[16]) begin
                    failures++;
                    $display("[TB] FAIL b2b_result n=%0d got=%b/%h want=%b/%h", nPronto, erro, registradorout, esperado[16], esperado[15:0]);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (nPronto !== 2 || espaco !== 18 || seguido !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_pulses got count=%0d spacing=%0d want count=2 spacing=18", nPronto, espaco);
        end
        waitPronto(40, lat);
        esperado = popExp();
        checks++;
        if (lat < 0 || registradorout !== esperado[15:0]) begin
            failures++;
            $display("[TB] FAIL b2b_third lat=%0d got=%h want=%h", lat, registradorout, esperado[15:0]);
        end
        checks++;
        if (expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_left got=%0d want=0", expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
